dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter D_ADDRESSWIDTH, default 32: width of the address bus on both sides.
REQ-002 SHALL have parameter DM_DATAWIDTH, default 32: width of the write and load data buses.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have, for each requester i in {0,1}, ports ri_en (in, 1), ri_op (in, 4, load/store op code), ri_address (in, D_ADDRESSWIDTH), ri_writedata (in, DM_DATAWIDTH), ri_stalled (out, 1) and ri_loadresult (out, DM_DATAWIDTH).
REQ-006 SHALL have memory-side ports m_en (out, 1), m_op (out, 4), m_address (out, D_ADDRESSWIDTH), m_writedata (out, DM_DATAWIDTH) and m_loadresult (in, DM_DATAWIDTH, valid one cycle after a load issue).
REQ-007 SHALL have port grant (out, 1): index of the current mux owner.

Function
REQ-008 SHALL implement states IDLE and RD.
REQ-009 A request is active when ri_en=1 and is a store when ri_op[3]=1; the requester SHALL hold all of its inputs stable while ri_stalled=1.
REQ-010 In IDLE with one active request, that requester SHALL win; with two active requests, the requester indicated by the priority pointer prio SHALL win.
REQ-011 In IDLE with a winner w: m_en=1; m_op, m_address and m_writedata = rw inputs; grant=w; prio SHALL become ~w at the edge.
REQ-012 A store winner SHALL see rw_stalled=0 in the grant cycle (single-cycle completion), and the state SHALL remain IDLE.
REQ-013 A load winner SHALL see rw_stalled=1 in the grant cycle; the block SHALL latch owner=w and go to RD.
REQ-014 In RD: m_en=0; m_op and m_address driven from the owner; r(owner)_stalled=0; r(owner)_loadresult=m_loadresult; next state IDLE.
REQ-015 An active requester that is not the completing winner SHALL see stalled=1 in every cycle, including cycles in RD.
REQ-016 An inactive requester SHALL see stalled=0.
REQ-017 A non-owner's loadresult SHALL be 0.
REQ-018 In IDLE with no active request: m_en=0, mux outputs driven from grant, and prio unchanged.
REQ-019 Worst-case wait with both requesting loads continuously SHALL be 2 cycles of the peer's access plus the requester's own 2-cycle load.
REQ-020 ri_en falling while ri_stalled=1 is a protocol violation; the block SHALL still complete RD and return to IDLE without a hang.
REQ-021 An access SHALL issue on m_en only from IDLE; no back-to-back issue across RD.

Reset
REQ-022 While resetn=0 the block SHALL force state=IDLE, prio=0, owner=0, grant=0, m_en=0, and all stalled outputs SHALL be 0.
REQ-023 Reset asserted during RD SHALL abandon the load immediately, with no memory write issued.
REQ-024 After resetn rises, the first arbitration SHALL occur on the next rising edge with prio=0.

Configuration
REQ-025 Macro DMEM_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win contention, and prio SHALL be held at 0.
REQ-026 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-010 and REQ-011.

Verification
REQ-027 Reset, then r0 SW addr 0x10 data 0xDEADBEEF -> m_en=1 for one cycle with m_op=8 and r0_stalled=0 in that cycle; grant=0.
REQ-028 r0 LW 0x10 alone, memory returns 0xDEADBEEF -> r0_stalled 1 then 0; r0_loadresult=0xDEADBEEF in RD; r1_loadresult=0.
REQ-029 r0 and r1 LW in the same cycle after reset -> r0 completes at cycle 2; r1 issues at cycle 3 and completes at cycle 4; r1_stalled=1 in cycles 1-3.
REQ-030 Both continuously store, round-robin build -> grant alternates 0,1,0,1 each cycle; with DMEM_ARB_FIXED_PRIO_EN -> grant stays 0 and r1_stalled remains 1.
REQ-031 resetn pulsed low in the RD cycle of an r1 load -> all stalled=0 and m_en=0 during reset; the next arbitration favours r0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two load/store requesters, the dmem_arbiter and the data memory.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int D_ADDRESSWIDTH = 32,
  parameter int DM_DATAWIDTH   = 32
);
  logic                      r0_en;
  logic [3:0]                r0_op;
  logic [D_ADDRESSWIDTH-1:0] r0_address;
  logic [DM_DATAWIDTH-1:0]   r0_writedata;
  logic                      r0_stalled;
  logic [DM_DATAWIDTH-1:0]   r0_loadresult;

  logic                      r1_en;
  logic [3:0]                r1_op;
  logic [D_ADDRESSWIDTH-1:0] r1_address;
  logic [DM_DATAWIDTH-1:0]   r1_writedata;
  logic                      r1_stalled;
  logic [DM_DATAWIDTH-1:0]   r1_loadresult;

  logic                      m_en;
  logic [3:0]                m_op;
  logic [D_ADDRESSWIDTH-1:0] m_address;
  logic [DM_DATAWIDTH-1:0]   m_writedata;
  logic [DM_DATAWIDTH-1:0]   m_loadresult;

  logic                      grant;

  modport slave (
    input  r0_en, r0_op, r0_address, r0_writedata,
    input  r1_en, r1_op, r1_address, r1_writedata,
    input  m_loadresult,
    output r0_stalled, r0_loadresult, r1_stalled, r1_loadresult,
    output m_en, m_op, m_address, m_writedata, grant
  );

  modport master (
    output r0_en, r0_op, r0_address, r0_writedata,
    output r1_en, r1_op, r1_address, r1_writedata,
    output m_loadresult,
    input  r0_stalled, r0_loadresult, r1_stalled, r1_loadresult,
    input  m_en, m_op, m_address, m_writedata, grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: stores finish in the grant cycle, loads take a second (RD) cycle.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int D_ADDRESSWIDTH = 32,
  parameter int DM_DATAWIDTH   = 32
) (
  input  logic           clk,
  input  logic           resetn,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, RD} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  logic   grant_q, grant_d;

  logic [1:0]                en;
  logic [3:0]                op    [2];
  logic [D_ADDRESSWIDTH-1:0] addr  [2];
  logic [DM_DATAWIDTH-1:0]   wdata [2];

  assign en       = {bus.r1_en, bus.r0_en};
  assign op[0]    = bus.r0_op;
  assign op[1]    = bus.r1_op;
  assign addr[0]  = bus.r0_address;
  assign addr[1]  = bus.r1_address;
  assign wdata[0] = bus.r0_writedata;
  assign wdata[1] = bus.r1_writedata;

  logic any_req;
  logic win;

  assign any_req = |en;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = ~en[0];
`else
  assign win = (&en) ? prio_q : en[1];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          prio_d  = 1'b0;
`else
          prio_d  = ~win;
`endif
          if (!op[win][3]) begin
            state_d = RD;
            owner_d = win;
          end
        end
      end
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic                    sel;
  logic                    m_en;
  logic [1:0]              stalled;
  logic [DM_DATAWIDTH-1:0] lr [2];

  always_comb begin
    sel     = grant_q;
    m_en    = 1'b0;
    stalled = 2'b00;
    lr[0]   = '0;
    lr[1]   = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          sel          = win;
          m_en         = 1'b1;
          stalled      = en;
          stalled[win] = ~op[win][3];
        end
      end
      RD: begin
        sel              = owner_q;
        stalled          = en;
        stalled[owner_q] = 1'b0;
        lr[owner_q]      = bus.m_loadresult;
      end
      default: ;
    endcase
    // Outputs are quiet while reset is held, even with requests already asserted.
    if (!resetn) begin
      sel     = 1'b0;
      m_en    = 1'b0;
      stalled = 2'b00;
      lr[0]   = '0;
      lr[1]   = '0;
    end
  end

  assign bus.m_en          = m_en;
  assign bus.m_op          = op[sel];
  assign bus.m_address     = addr[sel];
  assign bus.m_writedata   = wdata[sel];
  assign bus.grant         = sel;
  assign bus.r0_stalled    = stalled[0];
  assign bus.r1_stalled    = stalled[1];
  assign bus.r0_loadresult = lr[0];
  assign bus.r1_loadresult = lr[1];

endmodule
